// File: rtl/io_port_ctrl.sv
// Port-access responder: turns OUT/IN requests from the control unit into
// valid/ready handshakes with a peripheral, stalling fetch until completion.
module io_port_ctrl #(
    parameter int          DATA_W  = 8,
    parameter int          ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_port,
    input  logic              re_port,
    input  logic [ADDR_W-1:0] port_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    input  logic              err_clr,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] in_sel,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid
);

    typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT, DONE} state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam int unsigned TO_LIM  = TO_EN ? TIMEOUT - 1 : 0;
    localparam logic [15:0] TO_LAST = TO_LIM[15:0];

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        out_hs, in_hs, tmo;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        out_hs    = (state == OUT_WAIT) && out_valid && out_ready;
        in_hs     = (state == IN_WAIT) && in_valid && in_ready;
        tmo       = TO_EN && ((state == OUT_WAIT) || (state == IN_WAIT)) &&
                    (cnt == TO_LAST) && !out_hs && !in_hs;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (we_port)      state_nxt = OUT_WAIT;
                else if (re_port) state_nxt = IN_WAIT;
            end
            OUT_WAIT: if (out_hs || tmo) state_nxt = DONE;
            IN_WAIT:  if (in_hs || tmo)  state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign stall = (we_port | re_port) & (state != DONE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            in_sel    <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write takes priority when both requests arrive together.
                    if (we_port) begin
                        out_addr  <= port_addr;
                        out_data  <= wdata;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end else if (re_port) begin
                        in_sel   <= port_addr;
                        in_ready <= 1'b1;
                        cnt      <= '0;
                    end
                end
                OUT_WAIT: begin
                    if (out_hs || tmo)      out_valid <= 1'b0;
                    else if (cnt != 16'hFFFF) cnt     <= cnt + 16'd1;
                end
                IN_WAIT: begin
                    if (in_hs) begin
                        rdata    <= in_data;
                        in_ready <= 1'b0;
                    end else if (tmo) begin
                        rdata    <= '0;
                        in_ready <= 1'b0;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
            // A timeout outranks a simultaneous clear so the error is never lost.
            if (tmo)          err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboarded bench for io_port_ctrl: expected completions are queued when a
// request is driven and checked when the done pulse appears.
module tb_io_port_ctrl;

    localparam int TO = 8;

    logic       clk = 0;
    logic       reset;
    logic       we_port, re_port, err_clr, out_ready, in_valid;
    logic [1:0] port_addr;
    logic [7:0] wdata, in_data;
    logic [7:0] rdata, out_data;
    logic [1:0] out_addr, in_sel;
    logic       stall, done, err, out_valid, in_ready;

    io_port_ctrl #(.DATA_W(8), .ADDR_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .we_port(we_port), .re_port(re_port),
        .port_addr(port_addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .done(done), .err(err), .err_clr(err_clr), .out_data(out_data),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .in_sel(in_sel), .in_ready(in_ready), .in_data(in_data), .in_valid(in_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rd;
        logic       er;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc_cnt = 0;
    int         last_done = 0;
    int         prev_done = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rdata", {24'd0, rdata}, {24'd0, e.rd});
                check("err", {31'd0, err}, {31'd0, e.er});
            end
            prev_done = last_done;
            last_done = cyc_cnt;
        end
    end

    // Starts on an IDLE negedge, returns on the negedge after DONE.
    task automatic xfer(input logic w, input logic r, input logic [1:0] a,
                        input logic [7:0] wd, input logic [7:0] id, input int d,
                        input logic tmo, input logic clr);
        int exp_done;
        bit seen;
        seen      = 0;
        we_port   = w;
        re_port   = r;
        port_addr = a;
        wdata     = wd;
        in_data   = id;
        err_clr   = clr;
        if (d == 0 && !tmo) begin
            out_ready = w;
            in_valid  = r;
        end
        if (!w) exp_rdata = tmo ? 8'h00 : id;
        if (tmo) exp_err = 1'b1;
        sb.push_back('{rd: exp_rdata, er: exp_err});
        exp_done = tmo ? TO + 1 : d + 2;
        #1 check("stall_req", {31'd0, stall}, 1);
        for (int cyc = 1; cyc <= TO + 12; cyc++) begin
            @(negedge clk);
            if (done) begin
                check("done_cyc", cyc, exp_done);
                check("stall_done", {31'd0, stall}, 0);
                check("out_valid_done", {31'd0, out_valid}, 0);
                check("in_ready_done", {31'd0, in_ready}, 0);
                seen = 1;
                break;
            end
            check("stall_wait", {31'd0, stall}, 1);
            if (w) begin
                check("out_valid", {31'd0, out_valid}, 1);
                check("out_addr", {30'd0, out_addr}, {30'd0, a});
                check("out_data", {24'd0, out_data}, {24'd0, wd});
                check("in_ready_idle", {31'd0, in_ready}, 0);
            end else begin
                check("in_ready", {31'd0, in_ready}, 1);
                check("in_sel", {30'd0, in_sel}, {30'd0, a});
                check("out_valid_idle", {31'd0, out_valid}, 0);
            end
            if (!tmo && d != 0 && cyc == d + 1) begin
                out_ready = w;
                in_valid  = ~w;
            end
        end
        if (!seen) check("done_seen", 0, 1);
        we_port   = 0;
        re_port   = 0;
        out_ready = 0;
        in_valid  = 0;
        err_clr   = 0;
        @(negedge clk);
    endtask

    task automatic clear_err();
        err_clr = 1;
        @(negedge clk);
        check("err_clr", {31'd0, err}, 0);
        err_clr = 0;
        exp_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; we_port = 0; re_port = 0; err_clr = 0; out_ready = 0;
        in_valid = 0; port_addr = 0; wdata = 0; in_data = 0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_out_addr", {30'd0, out_addr}, 0);
        check("rst_in_sel", {30'd0, in_sel}, 0);
        check("rst_rdata", {24'd0, rdata}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        reset = 0;
        @(negedge clk);

        xfer(1, 0, 2'd2, 8'hA5, 8'h00, 0, 0, 0);
        xfer(0, 1, 2'd1, 8'h00, 8'h3C, 4, 0, 0);
        xfer(1, 0, 2'd3, 8'h5A, 8'h00, 0, 1, 0);
        clear_err();
        xfer(0, 1, 2'd0, 8'h00, 8'h99, 0, 1, 1);
        clear_err();
        xfer(1, 1, 2'd1, 8'hC3, 8'h77, 0, 0, 0);

        xfer(1, 0, 2'd0, 8'h11, 8'h00, 0, 0, 0);
        xfer(0, 1, 2'd3, 8'h00, 8'h22, 0, 0, 0);
        check("b2b_gap", last_done - prev_done, 3);

        re_port = 1; port_addr = 2'd2; in_valid = 0;
        repeat (3) @(negedge clk);
        check("mid_in_ready", {31'd0, in_ready}, 1);
        reset = 1;
        @(negedge clk);
        check("rst_mid_in_ready", {31'd0, in_ready}, 0);
        check("rst_mid_rdata", {24'd0, rdata}, 0);
        check("rst_mid_done", {31'd0, done}, 0);
        reset = 0; re_port = 0;
        exp_rdata = 8'h00; exp_err = 0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, in_ready}, 0);
        check("post_rst_done", {31'd0, done}, 0);
        xfer(1, 0, 2'd1, 8'h6E, 8'h00, 2, 0, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
